// File: rtl/mem_bank_pipe.sv
// mem_bank_pipe: parametrised single-port word memory with byte write strobes,
// a registered read pipeline of RD_LAT stages, out-of-range address detection
// and a zero-fill sequence that runs after reset.
//
// Handshake: a request is accepted on a rising clock edge when i_sel && o_ready.
// There is no backpressure. Every accepted read returns exactly one o_rvalid
// pulse, RD_LAT cycles after the accept edge. o_err is registered at the accept
// edge, so it shows in the cycle that follows the request.
module mem_bank_pipe #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_sel,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_wen,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                o_ready,
  output logic                o_busy,
  output logic                o_rvalid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_err,
  output logic                o_state
);

  localparam int NB  = DATA_W / 8;
  localparam int OFF = $clog2(NB);
  localparam int IDX = $clog2(DEPTH);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX-1:0]    r_fill_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [RD_LAT-1:0] r_pv;
  logic [DATA_W-1:0] r_pd [RD_LAT];
  logic              r_err;

  logic              w_accept;
  logic              w_oor;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_fill_on;
  logic              w_fill_last;
  logic [IDX-1:0]    w_idx;
  logic [DATA_W-1:0] w_rd_word;

  // Address decode: low OFF bits select a byte within the word and are ignored;
  // any bit above the word index marks the request as out of range.
  assign w_idx       = i_addr[OFF+IDX-1:OFF];
  assign w_oor       = |(i_addr >> (OFF + IDX));
  assign w_accept    = i_sel && (r_state == ST_IDLE);
  assign w_wr_acc    = w_accept && i_wen && !w_oor;
  assign w_rd_acc    = w_accept && !i_wen;
  assign w_fill_on   = (r_state == ST_INIT) && (INIT_CLEAR != 0);
  assign w_fill_last = (r_fill_cnt == IDX'(DEPTH - 1));
  assign w_rd_word   = w_oor ? '0 : r_mem[w_idx];

  // State register; reset always lands in INIT so ready stays low during reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_INIT;
    else            r_state <= w_state_nxt;
  end

  // Next state: leave INIT once the last word is cleared, or at once if no fill.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: if ((INIT_CLEAR == 0) || w_fill_last) w_state_nxt = ST_IDLE;
      ST_IDLE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Fill counter walks 0..DEPTH-1 while in INIT; reset restarts it from word 0.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)     r_fill_cnt <= '0;
    else if (w_fill_on) r_fill_cnt <= r_fill_cnt + 1'b1;
  end

  // Storage array (not reset): zero-fill during INIT, byte-lane writes in IDLE.
  always_ff @(posedge i_clock) begin
    if (w_fill_on) begin
      r_mem[r_fill_cnt] <= '0;
    end else if (w_wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (i_wstrb[b]) r_mem[w_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // Read pipeline and error flag; each data stage only loads when its
  // predecessor is valid, so the last stage holds its value between pulses.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pv  <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < RD_LAT; k++) r_pd[k] <= '0;
    end else begin
      r_err   <= w_accept && w_oor;
      r_pv[0] <= w_rd_acc;
      if (w_rd_acc) r_pd[0] <= w_rd_word;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k] <= r_pv[k-1];
        if (r_pv[k-1]) r_pd[k] <= r_pd[k-1];
      end
    end
  end

  assign o_ready  = (r_state == ST_IDLE);
  assign o_busy   = w_fill_on;
  assign o_rvalid = r_pv[RD_LAT-1];
  assign o_rdata  = r_pd[RD_LAT-1];
  assign o_err    = r_err;
  assign o_state  = r_state;

endmodule

// File: tb/tb_mem_bank_pipe.sv
// Testbench for mem_bank_pipe: randomized and directed traffic against a word
// array model; a negedge monitor pops expected read data / error pulses.
module tb_mem_bank_pipe;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int RD_LAT = 3;

  logic              clk;
  logic              i_reset_n;
  logic              i_sel;
  logic [ADDR_W-1:0] i_addr;
  logic              i_wen;
  logic [3:0]        i_wstrb;
  logic [DATA_W-1:0] i_wdata;
  logic              o_ready;
  logic              o_busy;
  logic              o_rvalid;
  logic [DATA_W-1:0] o_rdata;
  logic              o_err;
  logic              o_state;

  mem_bank_pipe #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .INIT_CLEAR(1)
  ) dut (
    .i_clock(clk), .i_reset_n(i_reset_n), .i_sel(i_sel), .i_addr(i_addr),
    .i_wen(i_wen), .i_wstrb(i_wstrb), .i_wdata(i_wdata), .o_ready(o_ready),
    .o_busy(o_busy), .o_rvalid(o_rvalid), .o_rdata(o_rdata), .o_err(o_err),
    .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];
  int                due_q[$];
  int                err_q[$];
  logic [DATA_W-1:0] mdl [DEPTH];
  bit                mdl_ready = 0;

  logic [DATA_W-1:0] mon_e;
  int                mon_d;
  bit                mon_err;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (o_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected cyc=%0d rdata=%h", cyc, o_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_d = due_q.pop_front();
        if (o_rdata !== mon_e || mon_d != cyc) begin
          errors++;
          $display("FAIL rdata got=%h at cyc %0d exp=%h at cyc %0d", o_rdata, cyc, mon_e, mon_d);
        end
      end
    end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
      checks++;
      errors++;
      mon_e = exp_q.pop_front();
      mon_d = due_q.pop_front();
      $display("FAIL rvalid_missing got=0 exp=1 (data %h due cyc %0d)", mon_e, mon_d);
    end
    mon_err = 0;
    while (err_q.size() != 0 && err_q[0] <= cyc) begin
      if (err_q[0] == cyc) mon_err = 1;
      void'(err_q.pop_front());
    end
    checks++;
    if (o_err !== mon_err) begin
      errors++;
      $display("FAIL err_pulse got=%b exp=%b cyc=%0d", o_err, mon_err, cyc);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic drive(input logic sel, input logic wen, input logic [31:0] addr,
                       input logic [3:0] strb, input logic [31:0] data,
                       input bit use_exp, input logic [31:0] exp_v);
    bit oor;
    int w;
    i_sel = sel; i_wen = wen; i_addr = addr; i_wstrb = strb; i_wdata = data;
    oor = (addr >= DEPTH * 4);
    w   = (addr / 4) % DEPTH;
    if (mdl_ready && sel) begin
      if (oor) err_q.push_back(cyc + 1);
      if (wen) begin
        if (!oor)
          for (int b = 0; b < 4; b++)
            if (strb[b]) mdl[w][8*b +: 8] = data[8*b +: 8];
      end else begin
        exp_q.push_back(use_exp ? exp_v : (oor ? 32'h0 : mdl[w]));
        due_q.push_back(cyc + RD_LAT);
      end
    end
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] data);
    drive(1'b1, 1'b1, addr, strb, data, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] addr);
    drive(1'b1, 1'b0, addr, 4'($urandom), $urandom, 1'b0, 32'h0);
  endtask

  task automatic rd_exp(input logic [31:0] addr, input logic [31:0] exp_v);
    drive(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b1, exp_v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Assert reset mid low-phase and drop everything the model expected.
  task automatic assert_reset();
    #2;
    i_reset_n = 1'b0;
    i_sel     = 1'b0;
    mdl_ready = 0;
    exp_q.delete();
    due_q.delete();
    err_q.delete();
    @(negedge clk);
  endtask

  // Release reset and count busy cycles while throwing junk requests at it.
  task automatic release_and_fill();
    int n;
    n = 0;
    i_reset_n = 1'b1;
    while (o_busy === 1'b1 && n < 100) begin
      n++;
      i_sel = 1'($urandom_range(0, 1)); i_wen = 1'($urandom_range(0, 1));
      i_addr = $urandom_range(0, 255); i_wstrb = 4'($urandom); i_wdata = $urandom;
      @(negedge clk);
    end
    i_sel = 1'b0;
    chk("busy_cycles", n, DEPTH);
    chk("ready_after_fill", {30'h0, o_ready, o_busy}, 32'h2);
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    mdl_ready = 1;
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] a;
  initial begin
    i_reset_n = 1'b0; i_sel = 1'b0; i_wen = 1'b0; i_addr = '0; i_wstrb = '0; i_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_busy", o_busy, 1);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_err", o_err, 0);

    // Fill length and zeroed contents.
    release_and_fill();
    for (int i = 0; i < DEPTH; i++) rd_exp(i * 4, 32'h0);
    idle(RD_LAT + 1);

    // Byte strobes.
    wr(32'h10, 4'hF, 32'hDEADBEEF);
    wr(32'h10, 4'b0101, 32'h11223344);
    rd_exp(32'h10, 32'hDE22BE44);
    wr(32'h14, 4'h0, 32'hFFFFFFFF);
    rd_exp(32'h14, 32'h0);
    idle(2);

    // Back-to-back reads, ordering and latency.
    wr(32'h0, 4'hF, $urandom);
    wr(32'h4, 4'hF, $urandom);
    wr(32'h8, 4'hF, $urandom);
    rd(32'h0); rd(32'h4); rd(32'h8);
    idle(RD_LAT + 1);

    // Out-of-range accesses.
    wr(32'h0, 4'hF, 32'h12345678);
    wr(32'h1000, 4'hF, 32'hFFFFFFFF);
    rd_exp(32'h0, 32'h12345678);
    rd_exp(32'h1000, 32'h0);
    rd_exp(32'h8000_0000, 32'h0);
    idle(2);

    // Write then read on the very next cycle; low address bits ignored.
    wr(32'h20, 4'hF, 32'hA5A5A5A5);
    rd_exp(32'h20, 32'hA5A5A5A5);
    rd_exp(32'h23, 32'hA5A5A5A5);
    idle(RD_LAT + 1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) a = 32'h40 + $urandom_range(0, 4095);
      else                           a = $urandom_range(0, DEPTH * 4 - 1);
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
            4'($urandom), $urandom, 1'b0, 32'h0);
    end
    idle(RD_LAT + 1);

    // Reset with reads in flight, then again partway through the fill.
    for (int i = 0; i < DEPTH; i++) wr(i * 4, 4'hF, 32'hC0DE0000 + i);
    rd(32'h0);
    rd(32'h4);
    assert_reset();
    @(negedge clk);
    i_reset_n = 1'b1;
    repeat (5) @(negedge clk);
    assert_reset();
    @(negedge clk);
    release_and_fill();
    for (int i = 0; i < DEPTH; i++) rd_exp(i * 4, 32'h0);
    idle(RD_LAT + 3);
    chk("drain_exp_q", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
